// File: rtl/card_dealer.sv
// Card dealer: samples the free-running game counter on a draw request, reduces it
// mod 13 to a rank, and probes forward past exhausted ranks to deal from a finite shoe.
module card_dealer #(
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned NUM_DECKS = 1
) (
    input  logic             clk_50M,
    input  logic             i_Reset,
    input  logic [WIDTH-1:0] i_Count,
    input  logic             i_Draw,
    input  logic             i_Shuffle,
    output logic [3:0]       o_Card,
    output logic [3:0]       o_Points,
    output logic             o_IsAce,
    output logic             o_Valid,
    output logic             o_Busy,
    output logic [7:0]       o_Remaining,
    output logic             o_DeckEmpty
);

    localparam int unsigned NUM_RANKS = 13;
    localparam int unsigned PER_RANK  = 4 * NUM_DECKS;
    localparam int unsigned SHOE_SIZE = 52 * NUM_DECKS;
    localparam int unsigned CW        = $clog2(PER_RANK + 1);
    localparam int unsigned RANK_W    = 4;

    localparam logic [WIDTH-1:0]  SEED_MOD  = WIDTH'(NUM_RANKS);
    localparam logic [CW-1:0]     RANK_FULL = CW'(PER_RANK);
    localparam logic [7:0]        SHOE_FULL = 8'(SHOE_SIZE);
    localparam logic [RANK_W-1:0] LAST_IDX  = RANK_W'(NUM_RANKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        PROBE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  seed_q, seed_d;
    logic [RANK_W-1:0] cand_q, cand_d;
    logic [CW-1:0]     used_q [NUM_RANKS];
    logic [CW-1:0]     used_d [NUM_RANKS];
    logic [7:0]        remaining_d;
    logic [3:0]        card_d, points_d;
    logic              ace_d, valid_d;

    // State, usage table and registered outputs
    always_ff @(posedge clk_50M or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q     <= IDLE;
            seed_q      <= '0;
            cand_q      <= '0;
            for (int i = 0; i < NUM_RANKS; i++) used_q[i] <= '0;
            o_Remaining <= SHOE_FULL;
            o_Card      <= '0;
            o_Points    <= '0;
            o_IsAce     <= 1'b0;
            o_Valid     <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            cand_q      <= cand_d;
            for (int i = 0; i < NUM_RANKS; i++) used_q[i] <= used_d[i];
            o_Remaining <= remaining_d;
            o_Card      <= card_d;
            o_Points    <= points_d;
            o_IsAce     <= ace_d;
            o_Valid     <= valid_d;
        end
    end

    // Next-state and datapath; shuffle overrides everything else
    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        cand_d      = cand_q;
        for (int i = 0; i < NUM_RANKS; i++) used_d[i] = used_q[i];
        remaining_d = o_Remaining;
        card_d      = o_Card;
        points_d    = o_Points;
        ace_d       = o_IsAce;
        valid_d     = 1'b0;

        if (i_Shuffle) begin
            state_d     = IDLE;
            for (int i = 0; i < NUM_RANKS; i++) used_d[i] = '0;
            remaining_d = SHOE_FULL;
            card_d      = '0;
            points_d    = '0;
            ace_d       = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_Draw && !o_DeckEmpty) begin
                        seed_d  = i_Count;
                        state_d = REDUCE;
                    end
                end
                REDUCE: begin
                    cand_d  = RANK_W'(seed_q % SEED_MOD);
                    state_d = PROBE;
                end
                PROBE: begin
                    if (used_q[cand_q] < RANK_FULL) begin
                        used_d[cand_q] = used_q[cand_q] + CW'(1);
                        remaining_d    = o_Remaining - 8'd1;
                        card_d         = cand_q + 4'd1;
                        points_d       = (cand_q >= 4'd9) ? 4'd10 : cand_q + 4'd1;
                        ace_d          = (cand_q == 4'd0);
                        valid_d        = 1'b1;
                        state_d        = IDLE;
                    end else begin
                        // Rank exhausted: walk to the next rank, wrapping K -> A
                        cand_d = (cand_q == LAST_IDX) ? 4'd0 : cand_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign o_Busy      = (state_q != IDLE);
    assign o_DeckEmpty = (o_Remaining == 8'd0);

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: reset, rank reduction, exhaustion, empty shoe,
// shuffle abort and held-request behaviour against hand-computed expectations.
module tb_card_dealer;

    logic        clk_50M = 1'b0;
    logic        i_Reset;
    logic [11:0] i_Count;
    logic        i_Draw;
    logic        i_Shuffle;
    logic [3:0]  o_Card, o_Points;
    logic        o_IsAce, o_Valid, o_Busy, o_DeckEmpty;
    logic [7:0]  o_Remaining;

    int n_checks = 0;
    int n_fail   = 0;

    card_dealer #(.WIDTH(12), .NUM_DECKS(1)) dut (
        .clk_50M     (clk_50M),
        .i_Reset     (i_Reset),
        .i_Count     (i_Count),
        .i_Draw      (i_Draw),
        .i_Shuffle   (i_Shuffle),
        .o_Card      (o_Card),
        .o_Points    (o_Points),
        .o_IsAce     (o_IsAce),
        .o_Valid     (o_Valid),
        .o_Busy      (o_Busy),
        .o_Remaining (o_Remaining),
        .o_DeckEmpty (o_DeckEmpty)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic tick;
        @(posedge clk_50M);
        #1;
    endtask

    task automatic do_shuffle;
        i_Shuffle = 1'b1;
        tick;
        i_Shuffle = 1'b0;
    endtask

    // One-cycle draw pulse; lat counts edges from the sampling edge to o_Valid (20 = timeout)
    task automatic draw_one(input logic [11:0] cnt, output logic [3:0] card,
                            output logic [3:0] pts, output logic ace, output int lat);
        i_Count = cnt;
        i_Draw  = 1'b1;
        tick;
        i_Draw  = 1'b0;
        lat     = 1;
        while (!o_Valid && lat < 20) begin
            tick;
            lat++;
        end
        card = o_Card;
        pts  = o_Points;
        ace  = o_IsAce;
    endtask

    task automatic test_reset;
        logic [3:0] c, p;
        logic       a;
        int         lat;
        i_Reset = 1'b0; i_Draw = 1'b0; i_Shuffle = 1'b0; i_Count = '0;
        repeat (3) tick;
        i_Reset = 1'b1;
        tick;
        n_checks++; if (o_Remaining !== 8'd52) begin n_fail++; $display("FAIL reset_remaining got %0d want 52", o_Remaining); end
        n_checks++; if (o_DeckEmpty !== 1'b0) begin n_fail++; $display("FAIL reset_empty got %b want 0", o_DeckEmpty); end
        n_checks++; if (o_Busy !== 1'b0 || o_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_busy_valid got %b%b want 00", o_Busy, o_Valid); end
        n_checks++; if (o_Card !== 4'd0 || o_Points !== 4'd0 || o_IsAce !== 1'b0) begin n_fail++; $display("FAIL reset_card got %0d/%0d/%b want 0/0/0", o_Card, o_Points, o_IsAce); end
        // Async clear: draw a card, then pull reset between clock edges
        draw_one(12'd9, c, p, a, lat);
        n_checks++; if (c !== 4'd10 || o_Remaining !== 8'd51) begin n_fail++; $display("FAIL reset_predraw got card %0d rem %0d want 10 51", c, o_Remaining); end
        #4 i_Reset = 1'b0;
        #1;
        n_checks++; if (o_Card !== 4'd0 || o_Points !== 4'd0 || o_Remaining !== 8'd52) begin n_fail++; $display("FAIL reset_async got card %0d pts %0d rem %0d want 0 0 52", o_Card, o_Points, o_Remaining); end
        tick;
        i_Reset = 1'b1;
        tick;
    endtask

    task automatic test_single_draw;
        i_Count = 12'd25;
        i_Draw  = 1'b1;
        tick;
        i_Draw  = 1'b0;
        n_checks++; if (o_Busy !== 1'b1 || o_Valid !== 1'b0) begin n_fail++; $display("FAIL single_n1 got busy %b valid %b want 1 0", o_Busy, o_Valid); end
        tick;
        n_checks++; if (o_Busy !== 1'b1 || o_Valid !== 1'b0) begin n_fail++; $display("FAIL single_n2 got busy %b valid %b want 1 0", o_Busy, o_Valid); end
        tick;
        n_checks++; if (o_Valid !== 1'b1 || o_Busy !== 1'b0) begin n_fail++; $display("FAIL single_n3 got valid %b busy %b want 1 0", o_Valid, o_Busy); end
        n_checks++; if (o_Card !== 4'd13 || o_Points !== 4'd10 || o_IsAce !== 1'b0) begin n_fail++; $display("FAIL single_card got %0d/%0d/%b want 13/10/0", o_Card, o_Points, o_IsAce); end
        n_checks++; if (o_Remaining !== 8'd51) begin n_fail++; $display("FAIL single_remaining got %0d want 51", o_Remaining); end
        tick;
        n_checks++; if (o_Valid !== 1'b0 || o_Card !== 4'd13) begin n_fail++; $display("FAIL single_hold got valid %b card %0d want 0 13", o_Valid, o_Card); end
    endtask

    task automatic test_mod_table;
        logic [11:0] cnts [5] = '{12'd25, 12'd4095, 12'd2000, 12'd9, 12'd14};
        logic [3:0]  ecard[5] = '{4'd13, 4'd1, 4'd12, 4'd10, 4'd2};
        logic [3:0]  epts [5] = '{4'd10, 4'd1, 4'd10, 4'd10, 4'd2};
        logic        eace [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0]  c, p;
        logic        a;
        int          lat;
        do_shuffle;
        for (int i = 0; i < 5; i++) begin
            draw_one(cnts[i], c, p, a, lat);
            n_checks++;
            if (c !== ecard[i] || p !== epts[i] || a !== eace[i] || lat != 3) begin
                n_fail++;
                $display("FAIL mod_%0d count %0d got %0d/%0d/%b lat %0d want %0d/%0d/%b lat 3",
                         i, cnts[i], c, p, a, lat, ecard[i], epts[i], eace[i]);
            end
        end
    endtask

    task automatic test_rank_exhaustion;
        logic [3:0] c, p;
        logic       a;
        int         lat;
        do_shuffle;
        for (int i = 0; i < 5; i++) begin
            draw_one(12'd13, c, p, a, lat);
            n_checks++;
            if (i < 4 && (c !== 4'd1 || p !== 4'd1 || a !== 1'b1 || lat != 3)) begin
                n_fail++; $display("FAIL exhaust_%0d got %0d/%0d/%b lat %0d want 1/1/1 lat 3", i, c, p, a, lat);
            end else if (i == 4 && (c !== 4'd2 || p !== 4'd2 || a !== 1'b0 || lat != 4)) begin
                n_fail++; $display("FAIL exhaust_4 got %0d/%0d/%b lat %0d want 2/2/0 lat 4", c, p, a, lat);
            end
        end
        n_checks++; if (o_Remaining !== 8'd47) begin n_fail++; $display("FAIL exhaust_remaining got %0d want 47", o_Remaining); end
    endtask

    task automatic test_empty_shoe;
        logic [3:0] c, p;
        logic       a;
        int         lat;
        int         bad;
        do_shuffle;
        for (int k = 0; k < 52; k++) begin
            draw_one(12'd0, c, p, a, lat);
            n_checks++;
            if (c !== 4'(k / 4 + 1) || lat != 3 + k / 4) begin
                n_fail++; $display("FAIL empty_draw_%0d got card %0d lat %0d want %0d lat %0d", k, c, lat, k / 4 + 1, 3 + k / 4);
            end
        end
        n_checks++; if (o_Remaining !== 8'd0 || o_DeckEmpty !== 1'b1) begin n_fail++; $display("FAIL empty_flag got rem %0d empty %b want 0 1", o_Remaining, o_DeckEmpty); end
        i_Draw = 1'b1;
        bad    = 0;
        repeat (20) begin
            tick;
            if (o_Busy !== 1'b0 || o_Valid !== 1'b0) bad++;
        end
        i_Draw = 1'b0;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL empty_ignore got %0d busy/valid cycles want 0", bad); end
    endtask

    task automatic test_shuffle_mid_draw;
        logic [3:0] c, p;
        logic       a;
        int         lat;
        int         bad;
        do_shuffle;
        draw_one(12'd4, c, p, a, lat);
        n_checks++; if (c !== 4'd5) begin n_fail++; $display("FAIL shuf_pre got %0d want 5", c); end
        i_Count = 12'd4;
        i_Draw  = 1'b1;
        tick;
        i_Draw  = 1'b0;
        tick;
        n_checks++; if (o_Busy !== 1'b1) begin n_fail++; $display("FAIL shuf_probe_busy got %b want 1", o_Busy); end
        i_Shuffle = 1'b1;
        tick;
        i_Shuffle = 1'b0;
        n_checks++; if (o_Valid !== 1'b0 || o_Busy !== 1'b0) begin n_fail++; $display("FAIL shuf_abort got valid %b busy %b want 0 0", o_Valid, o_Busy); end
        n_checks++; if (o_Remaining !== 8'd52 || o_Card !== 4'd0 || o_Points !== 4'd0 || o_IsAce !== 1'b0) begin n_fail++; $display("FAIL shuf_state got rem %0d card %0d pts %0d ace %b want 52 0 0 0", o_Remaining, o_Card, o_Points, o_IsAce); end
        bad = 0;
        repeat (4) begin
            tick;
            if (o_Valid !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL shuf_no_valid got %0d strobes want 0", bad); end
        draw_one(12'd4, c, p, a, lat);
        n_checks++; if (c !== 4'd5 || p !== 4'd5 || lat != 3 || o_Remaining !== 8'd51) begin n_fail++; $display("FAIL shuf_post got card %0d pts %0d lat %0d rem %0d want 5 5 3 51", c, p, lat, o_Remaining); end
    endtask

    task automatic test_held_request;
        int lat;
        int bad;
        do_shuffle;
        i_Count = 12'd7;
        i_Draw  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            lat = 0;
            do begin
                tick;
                lat++;
            end while (!o_Valid && lat < 20);
            if (i == 4) i_Draw = 1'b0;
            n_checks++;
            if (i < 4 && (o_Card !== 4'd8 || o_Points !== 4'd8 || lat != 3)) begin
                n_fail++; $display("FAIL held_%0d got card %0d pts %0d gap %0d want 8 8 3", i, o_Card, o_Points, lat);
            end else if (i == 4 && (o_Card !== 4'd9 || o_Points !== 4'd9 || lat != 4)) begin
                n_fail++; $display("FAIL held_4 got card %0d pts %0d gap %0d want 9 9 4", o_Card, o_Points, lat);
            end
        end
        bad = 0;
        repeat (6) begin
            tick;
            if (o_Valid !== 1'b0 || o_Busy !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0 || o_Remaining !== 8'd47) begin n_fail++; $display("FAIL held_after got %0d extra cycles rem %0d want 0 47", bad, o_Remaining); end
    endtask

    initial begin
        test_reset;
        test_single_draw;
        test_mod_table;
        test_rank_exhaustion;
        test_empty_shoe;
        test_shuffle_mid_draw;
        test_held_request;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
